out_scan_ctrl: RTL and testbench
================================

Name: out_scan_ctrl

Overview:
Upstream driver for the 8-digit seven-segment output stage. It generates the digit-scan select with a programmable prescaler. It holds the two 16-bit display values presented to that stage. Processor writes use a valid/ready handshake into per-slot shadow registers, which commit only at frame boundaries so a displayed frame never tears.

Parameters:
DIV, 50000, clock cycles per digit slot (must be >= 1)
DIV_W, 16, prescaler counter width (must satisfy 2^DIV_W >= DIV)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
wr_valid  in  1  write request
wr_ready  out  1  slot can accept a write
wr_slot  in  1  target slot: 0 -> outval1, 1 -> outval2
wr_data  in  16  value to display (4 hex digits)
outval1  out  16  committed value for digits 0-3
outval2  out  16  committed value for digits 4-7
sel  out  3  active digit index, 0..7
frame_tick  out  1  one-cycle pulse marking first cycle of a new frame

Behaviour:
- Reset (reset=0, async): cnt=0, sel=0, outval1=outval2=0, shadow1=shadow2=0, pend1=pend2=0, frame_tick=0. Released: wr_ready=1.
- Prescaler cnt counts 0..DIV-1 and wraps to 0. tick = (cnt==DIV-1). With DIV=1, tick is asserted every cycle.
- On tick, sel <= sel+1, wrapping 7 -> 0. Each digit is held exactly DIV cycles, so a frame is 8*DIV cycles.
- frame_end = tick && sel==7 (combinational, internal).
- wr_ready = ~pend[wr_slot]. It is combinational from the pend registers and wr_slot only, never from wr_valid.
- Accept = wr_valid && wr_ready. On the accept edge: shadow[wr_slot] <= wr_data and pend[wr_slot] <= 1.
- Commit at the frame_end edge: for each slot with pend=1 before the edge, outvalN <= shadowN and pendN <= 0. Slots with pend=0 keep their value.
- Commit latency: the new outval becomes visible in the same cycle that sel becomes 0. frame_tick is registered and is 1 in exactly that cycle.
- Write accepted in the frame_end cycle (slot not pending): it becomes pending and is not committed in this frame. It commits at the next frame_end, 8*DIV cycles later.
- Write to a pending slot: wr_ready=0, and the requester holds wr_data. It is accepted the cycle after commit, when pend clears. This includes the case where the stall coincides with frame_end.
- Both slots may be pending at once. They commit on the same edge.
- wr_valid with wr_ready=0 has no effect. The handshake carries no ordering between slots.
- Reset mid-frame discards pending shadows and restarts scanning from sel=0, cnt=0.
- All outputs are registered except wr_ready.

Test Plan:
1. DIV=4, reset released: sel=0, outvals=0, wr_ready=1. sel steps every 4 cycles. After 32 cycles sel returns to 0 with frame_tick=1 for exactly 1 cycle, repeating every 32 cycles.
2. Write slot0=0x1234 at sel=2 -> wr_ready drops next cycle and outval1 stays 0 until frame end. outval1=0x1234 in the cycle sel becomes 0 and frame_tick=1. wr_ready returns to 1.
3. While slot0 is pending, present slot0=0xBEEF -> wr_ready=0 and it is held. It is accepted 1 cycle after commit. outval1=0xBEEF appears one frame (32 cycles) later. Slot1 writes remain ready throughout.
4. Write slot1=0x085B in the frame_end cycle -> outval2 is not updated at that boundary. It updates to 0x085B at the following frame_end, 32 cycles later.
5. Both slots written in one frame (0xAAAA, 0x5555) -> outval1 and outval2 update on the same edge.
6. Pending write plus reset pulled low at sel=5 -> all outputs clear immediately without a clock edge. After release: sel=0, pending data is lost, and outvals stay 0 across the next frame.

Source files
------------

// File: rtl/out_scan_ctrl.sv
// Digit-scan sequencer and frame-synchronous display registers for the
// 8-digit seven-segment output stage. Writes land in shadows and commit at frame end.
module out_scan_ctrl #(
   parameter int DIV   = 50000,
   parameter int DIV_W = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        wr_valid,
   output logic        wr_ready,
   input  logic        wr_slot,
   input  logic [15:0] wr_data,
   output logic [15:0] outval1,
   output logic [15:0] outval2,
   output logic [2:0]  sel,
   output logic        frame_tick
);

   logic [DIV_W-1:0] cnt;
   logic             tick;
   logic             frame_end;
   logic             accept;
   logic             pend1;
   logic             pend2;
   logic [15:0]      shadow1;
   logic [15:0]      shadow2;

   assign tick      = (cnt == DIV_W'(DIV - 1));
   assign frame_end = tick && (sel == 3'd7);

   // Handshake: a write transfers on any rising edge where wr_valid && wr_ready.
   // wr_ready depends only on the addressed slot's pend flag, never on wr_valid;
   // a stalled requester holds wr_slot/wr_data until the transfer happens.
   assign wr_ready = wr_slot ? ~pend2 : ~pend1;
   assign accept   = wr_valid && wr_ready;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + DIV_W'(1);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sel        <= 3'd0;
         frame_tick <= 1'b0;
      end else begin
         frame_tick <= frame_end;
         if (tick) begin
            sel <= sel + 3'd1;
         end
      end
   end

   // A slot is never accepted while pending, so commit and accept of the same
   // slot cannot collide; an accept on the frame_end edge waits a full frame.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         outval1 <= 16'h0000;
         shadow1 <= 16'h0000;
         pend1   <= 1'b0;
      end else begin
         if (frame_end && pend1) begin
            outval1 <= shadow1;
            pend1   <= 1'b0;
         end
         if (accept && !wr_slot) begin
            shadow1 <= wr_data;
            pend1   <= 1'b1;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         outval2 <= 16'h0000;
         shadow2 <= 16'h0000;
         pend2   <= 1'b0;
      end else begin
         if (frame_end && pend2) begin
            outval2 <= shadow2;
            pend2   <= 1'b0;
         end
         if (accept && wr_slot) begin
            shadow2 <= wr_data;
            pend2   <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_out_scan_ctrl.sv
// Bench for out_scan_ctrl: directed scenarios plus random writes, checked
// every cycle against a cycle-count based reference model.
module tb_out_scan_ctrl;

   localparam int DIV   = 4;
   localparam int DIV_W = 3;
   localparam int FRAME = 8 * DIV;

   logic        clock;
   logic        reset;
   logic        wr_valid;
   logic        wr_ready;
   logic        wr_slot;
   logic [15:0] wr_data;
   logic [15:0] outval1;
   logic [15:0] outval2;
   logic [2:0]  sel;
   logic        frame_tick;

   int n_checks;
   int n_errors;

   // reference model: cycles since reset, per-slot pending/shadow/output
   int          t;
   bit          m_pend[2];
   logic [15:0] m_shadow[2];
   logic [15:0] m_out[2];
   logic [31:0] exp_q[$];

   out_scan_ctrl #(.DIV(DIV), .DIV_W(DIV_W)) dut (
      .clock      (clock),
      .reset      (reset),
      .wr_valid   (wr_valid),
      .wr_ready   (wr_ready),
      .wr_slot    (wr_slot),
      .wr_data    (wr_data),
      .outval1    (outval1),
      .outval2    (outval2),
      .sel        (sel),
      .frame_tick (frame_tick)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, got, exp, t);
      end
   endtask

   task automatic model_reset();
      t = 0;
      exp_q.delete();
      for (int i = 0; i < 2; i++) begin
         m_pend[i]   = 1'b0;
         m_shadow[i] = 16'h0000;
         m_out[i]    = 16'h0000;
      end
   endtask

   task automatic check_outputs();
      logic [31:0] e;
      check_eq("sel", 32'(sel), 32'((t / DIV) % 8));
      check_eq("outval1", 32'(outval1), 32'(m_out[0]));
      check_eq("outval2", 32'(outval2), 32'(m_out[1]));
      check_eq("frame_tick", 32'(frame_tick), 32'((t > 0) && (t % FRAME == 0)));
      if (frame_tick) begin
         check_eq("commit_q_size", exp_q.size(), 1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq("commit_vals", {outval2, outval1}, e);
         end
      end
   endtask

   // One clock cycle: drive at negedge, check wr_ready, advance model at posedge.
   task automatic step(input logic v, input logic s, input logic [15:0] d, output bit acc);
      bit fe;
      wr_valid = v;
      wr_slot  = s;
      wr_data  = d;
      #1;
      check_eq("wr_ready", 32'(wr_ready), 32'(!m_pend[s]));
      acc = v && !m_pend[s];
      @(posedge clock);
      fe = ((t % FRAME) == FRAME - 1);
      if (fe) begin
         for (int i = 0; i < 2; i++) begin
            if (m_pend[i]) begin
               m_out[i]  = m_shadow[i];
               m_pend[i] = 1'b0;
            end
         end
         exp_q.push_back({m_out[1], m_out[0]});
      end
      if (acc) begin
         m_shadow[s] = d;
         m_pend[s]   = 1'b1;
      end
      t++;
      @(negedge clock);
      check_outputs();
   endtask

   task automatic idle_until(input int phase);
      bit acc;
      int k;
      k = 0;
      while ((t % FRAME) != phase && k < 2 * FRAME) begin
         step(1'b0, 1'($urandom_range(0, 1)), 16'($urandom), acc);
         k++;
      end
      check_eq("idle_until_phase", 32'(t % FRAME), 32'(phase));
   endtask

   task automatic idle(input int n);
      bit acc;
      for (int i = 0; i < n; i++) begin
         step(1'b0, 1'($urandom_range(0, 1)), 16'($urandom), acc);
      end
   endtask

   initial begin
      bit          acc;
      bit          hold;
      int          n;
      logic        rv;
      logic        rs;
      logic [15:0] rd;

      n_checks = 0;
      n_errors = 0;
      wr_valid = 1'b0;
      wr_slot  = 1'b0;
      wr_data  = 16'h0000;
      reset    = 1'b0;
      model_reset();
      repeat (2) @(negedge clock);
      check_outputs();
      check_eq("rst_wr_ready", 32'(wr_ready), 32'd1);
      reset = 1'b1;

      // scan cadence over two full frames
      idle(2 * FRAME + 1);

      // single write, then pending slot stalls until commit; slot1 stays ready
      idle_until(2 * DIV);
      step(1'b1, 1'b0, 16'h1234, acc);
      step(1'b0, 1'b1, 16'h0000, acc);
      n = 0;
      do begin
         step(1'b1, 1'b0, 16'hBEEF, acc);
         n++;
      end while (!acc && n < 4 * FRAME);
      idle_until(0);
      idle(FRAME + 1);

      // write in the frame_end cycle commits one frame later
      idle_until(FRAME - 1);
      step(1'b1, 1'b1, 16'h085B, acc);
      idle(2 * FRAME);

      // both slots pending, commit on the same edge
      idle_until(3);
      step(1'b1, 1'b0, 16'hAAAA, acc);
      step(1'b1, 1'b1, 16'h5555, acc);
      idle_until(0);
      idle(2);

      // stall coinciding with frame_end: pend slot0, then hold a second write across it
      idle_until(FRAME - 4);
      step(1'b1, 1'b0, 16'h1111, acc);
      n = 0;
      do begin
         step(1'b1, 1'b0, 16'h2222, acc);
         n++;
      end while (!acc && n < 4 * FRAME);
      idle(FRAME + 2);

      // async reset mid-frame with a pending write
      step(1'b1, 1'b1, 16'h7777, acc);
      idle_until(5 * DIV + 1);
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      check_eq("arst_sel", 32'(sel), 32'd0);
      check_eq("arst_outval1", 32'(outval1), 32'd0);
      check_eq("arst_outval2", 32'(outval2), 32'd0);
      check_eq("arst_frame_tick", 32'(frame_tick), 32'd0);
      check_eq("arst_wr_ready", 32'(wr_ready), 32'd1);
      @(negedge clock);
      reset = 1'b1;
      check_outputs();
      idle(FRAME + 4);

      // random traffic; a stalled request is held until accepted
      hold = 1'b0;
      rv = 1'b0;
      rs = 1'b0;
      rd = 16'h0000;
      repeat (1200) begin
         if (!hold) begin
            rv = ($urandom_range(0, 3) == 0);
            rs = 1'($urandom_range(0, 1));
            rd = 16'($urandom);
         end
         step(rv, rs, rd, acc);
         hold = rv && !acc;
      end
      idle(2 * FRAME);
      check_eq("commit_q_drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
